program_loader: RTL and testbench

//  Writer side of the instruction memory: fills it with a program that the CPU

---
 rtl/loader_pkg.sv | 15 +
 rtl/program_loader_if.sv | 25 ++
 rtl/loader_byte_pair.sv | 25 ++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and field widths shared by the program loader files
package loader_pkg;
    localparam int LEN_W = 16;
    localparam int CSUM_W = 8;
    typedef logic [3:0] state_t;
    localparam state_t IDLE    = 4'd0;
    localparam state_t LEN_HI  = 4'd1;
    localparam state_t LEN_LO  = 4'd2;
    localparam state_t DATA_HI = 4'd3;
    localparam state_t DATA_LO = 4'd4;
    localparam state_t WRITE   = 4'd5;
    localparam state_t CHECK   = 4'd6;
    localparam state_t DONE    = 4'd7;
    localparam state_t ERROR   = 4'd8;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input, instruction-memory write port and load status
interface program_loader_if #(parameter int ADDR_W = 6, parameter int DATA_W = 16);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err_length;
    logic              err_checksum;
    logic [ADDR_W:0]   word_count;
    modport master (
        output start, in_valid, in_byte,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
               err_length, err_checksum, word_count
    );
    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
               err_length, err_checksum, word_count
    );
endinterface

// File: rtl/loader_byte_pair.sv
// loader_byte_pair: assembles hi/lo stream bytes into a word, word_valid pulses after the lo byte
module loader_byte_pair (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  data,
    output logic [15:0] word,
    output logic        word_valid
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= lo_en;
            if (hi_en) word[15:8] <= data;
            if (lo_en) word[7:0]  <= data;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length/data/checksum byte stream and writes it into instruction memory
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input logic clk,
    input logic reset,
    program_loader_if.slave bus
);
    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [CSUM_W-1:0] csum;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              err_length;
    logic              err_checksum;
    logic [15:0]       word;
    logic              word_valid;
    logic              xfer;
    logic              restart;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  wc_next;

    assign bus.in_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    assign xfer         = bus.in_valid && bus.in_ready;
    assign restart      = bus.start && (state == IDLE || state == DONE || state == ERROR);
    assign len_next     = {len[15:8], bus.in_byte};
    assign wc_next      = LEN_W'(word_count) + LEN_W'(1);

    loader_byte_pair pair (
        .clk(clk),
        .reset(reset),
        .clear(restart),
        .hi_en(xfer && state == DATA_HI),
        .lo_en(xfer && state == DATA_LO),
        .data(bus.in_byte),
        .word(word),
        .word_valid(word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len          <= '0;
            csum         <= '0;
            word_count   <= '0;
            mem_addr     <= '0;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
        end else if (restart) begin
            state        <= LEN_HI;
            csum         <= '0;
            word_count   <= '0;
            mem_addr     <= '0;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
        end else begin
            case (state)
                LEN_HI: if (xfer) begin
                    len[15:8] <= bus.in_byte;
                    state     <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len[7:0] <= bus.in_byte;
                    if (len_next == '0 || len_next > LEN_W'(DEPTH)) begin
                        state      <= ERROR;
                        err_length <= 1'b1;
                    end else state <= DATA_HI;
                end
                DATA_HI: if (xfer) begin
                    csum  <= csum ^ bus.in_byte;
                    state <= DATA_LO;
                end
                DATA_LO: if (xfer) begin
                    csum  <= csum ^ bus.in_byte;
                    state <= WRITE;
                end
                WRITE: begin
                    word_count <= wc_next[ADDR_W:0];
                    // the address only advances when another word follows, so it never wraps past DEPTH-1
                    if (wc_next < len) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= DATA_HI;
                    end else state <= CHECK;
                end
                CHECK: if (xfer) begin
                    if (csum == bus.in_byte) state <= DONE;
                    else begin
                        state        <= ERROR;
                        err_checksum <= 1'b1;
                    end
                end
                IDLE, DONE, ERROR: state <= state;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_we       = word_valid;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = DATA_W'(word);
    assign bus.cpu_hold     = state != DONE;
    assign bus.done         = state == DONE;
    assign bus.err_length   = err_length;
    assign bus.err_checksum = err_checksum;
    assign bus.word_count   = word_count;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected memory writes are queued by stimulus and checked by a monitor
module tb_program_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    program_loader_if bus ();
    program_loader dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [21:0] exp_q[$];
    logic [15:0] prog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                chk("write", {10'b0, bus.mem_addr, bus.mem_wdata}, {10'b0, e});
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] len, input logic [7:0] cs, input bit gaps);
        foreach (prog[i]) exp_q.push_back({6'(i), prog[i]});
        pulse_start();
        send(len[15:8], gaps);
        send(len[7:0], gaps);
        foreach (prog[i]) begin
            logic [15:0] w;
            w = prog[i];
            send(w[15:8], gaps);
            send(w[7:0], gaps);
        end
        send(cs, gaps);
        repeat (2) @(negedge clk);
    endtask

    task automatic status(input string tag, input logic d, input logic hold,
                          input logic el, input logic ec, input logic [6:0] wc);
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(hold));
        chk({tag, "_err_length"}, 32'(bus.err_length), 32'(el));
        chk({tag, "_err_checksum"}, 32'(bus.err_checksum), 32'(ec));
        chk({tag, "_word_count"}, 32'(bus.word_count), 32'(wc));
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 1);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err_length"}, 32'(bus.err_length), 0);
        chk({tag, "_err_checksum"}, 32'(bus.err_checksum), 0);
        chk({tag, "_word_count"}, 32'(bus.word_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        #3;
        reset_values("reset");
        @(negedge clk);
        reset = 1'b1;

        // 1: three-word program, good checksum
        prog = '{16'h8001, 16'h4005, 16'hC102};
        load(16'd3, 8'h07, 1'b0);
        status("basic", 1'b1, 1'b0, 1'b0, 1'b0, 7'd3);

        // 2: same stream with idle bubbles
        load(16'd3, 8'h07, 1'b1);
        status("gaps", 1'b1, 1'b0, 1'b0, 1'b0, 7'd3);

        // 3: illegal lengths
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        status("len_zero", 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h41, 1'b0);
        repeat (2) @(negedge clk);
        status("len_65", 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        chk("len_65_in_ready", 32'(bus.in_ready), 0);

        // 4: bad checksum
        load(16'd3, 8'h06, 1'b0);
        status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1, 7'd3);

        // 5: asynchronous reset after the second write
        exp_q.push_back({6'd0, 16'h8001});
        exp_q.push_back({6'd1, 16'h4005});
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h80, 1'b0);
        send(8'h01, 1'b0);
        send(8'h40, 1'b0);
        send(8'h05, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        reset_values("midreset");
        chk("midreset_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        load(16'd3, 8'h07, 1'b0);
        status("reload", 1'b1, 1'b0, 1'b0, 1'b0, 7'd3);

        // 6: full-depth program then restart from DONE
        prog.delete();
        cs = 8'h00;
        for (int i = 0; i < 64; i++) begin
            logic [15:0] w;
            w = 16'h1000 + 16'(i * 37);
            prog.push_back(w);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        load(16'd64, cs, 1'b0);
        status("full", 1'b1, 1'b0, 1'b0, 1'b0, 7'd64);
        chk("full_last_addr", 32'(bus.mem_addr), 63);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("restart_cpu_hold", 32'(bus.cpu_hold), 1);
        chk("restart_done", 32'(bus.done), 0);
        chk("restart_word_count", 32'(bus.word_count), 0);
        chk("restart_in_ready", 32'(bus.in_ready), 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
